// File: rtl/f3m_mult_seq.sv
// Sequencer and operand/result buffer for one GF(3^593) PE multiplier:
// accepts an operand pair, drives load plus STEPS Horner steps, then holds the product.
module f3m_mult_seq #(
    parameter int M        = 593,
    parameter int WIDTH_D0 = 1187,
    parameter int STEPS    = 198
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*M-1:0]      a,
    input  logic [2*M-1:0]      b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*M-1:0]      res,
    output logic                busy,
    output logic [10:0]         pe_ctrl,
    output logic [WIDTH_D0:0]   pe_d0,
    output logic [2*M-1:0]      pe_d1,
    output logic [2*M-1:0]      pe_d2,
    input  logic [2*M-1:0]      pe_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        CAPT = 2'd3
    } state_t;

    localparam logic [7:0]  LAST_STEP = 8'(STEPS - 1);
    localparam logic [10:0] CTRL_LOAD = 11'h7C0;
    localparam logic [10:0] CTRL_STEP = 11'h03F;
    localparam logic [10:0] CTRL_NONE = 11'h000;

    state_t          state, state_nx;
    logic [7:0]      step_cnt;
    logic [2*M-1:0]  a_q, b_q;
    logic            accept;

    // No accept while a finished product is still waiting to be consumed.
    assign accept = (state == IDLE) && in_valid && !res_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Counter holds at STEPS-1 on the last step rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (state == LOAD) begin
            step_cnt <= '0;
        end else if (state == MULT && step_cnt != LAST_STEP) begin
            step_cnt <= step_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // The product is captured only in CAPT, so an aborted run never reaches res.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res       <= '0;
            res_valid <= 1'b0;
        end else if (state == CAPT) begin
            res       <= pe_out;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        pe_ctrl  = CTRL_NONE;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !res_valid;
                if (accept) state_nx = LOAD;
            end
            LOAD: begin
                pe_ctrl  = CTRL_LOAD;
                state_nx = MULT;
            end
            MULT: begin
                pe_ctrl = CTRL_STEP;
                if (step_cnt == LAST_STEP) state_nx = CAPT;
            end
            CAPT: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pe_d0 = {{(WIDTH_D0 + 1 - 2*M){1'b0}}, a_q};
    assign pe_d1 = b_q;
    assign pe_d2 = b_q;

endmodule

// File: tb/tb_f3m_mult_seq.sv
// Bench for f3m_mult_seq: behavioural PE, GF(3^593) reference model,
// table of operand pairs, scoreboard on the result handshake.
module tb_f3m_mult_seq;

    localparam int M  = 593;
    localparam int W  = 2 * M;
    localparam int CW = 1188;

    typedef logic [W-1:0]  elem_t;
    typedef logic [CW-1:0] cval_t;

    typedef struct {
        elem_t a;
        elem_t b;
        elem_t exp;
        string name;
    } vec_t;

    typedef struct {
        elem_t exp;
        string name;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    elem_t         a, b;
    logic          res_valid;
    logic          res_ready;
    elem_t         res;
    logic          busy;
    logic [10:0]   pe_ctrl;
    logic [CW-1:0] pe_d0;
    elem_t         pe_d1, pe_d2;
    elem_t         pe_out;

    int n_tests = 0;
    int n_fail  = 0;
    sb_t sb_q[$];

    f3m_mult_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .busy      (busy),
        .pe_ctrl   (pe_ctrl),
        .pe_d0     (pe_d0),
        .pe_d1     (pe_d1),
        .pe_d2     (pe_d2),
        .pe_out    (pe_out)
    );

    always #5 clk = ~clk;

    // ---------------- GF(3^593) arithmetic, p = x^593 + x^112 + 2 ----------------
    function automatic logic [1:0] tadd(input logic [1:0] x, input logic [1:0] y);
        return 2'((int'(x) + int'(y)) % 3);
    endfunction

    function automatic logic [1:0] tmul(input logic [1:0] x, input logic [1:0] y);
        return 2'((int'(x) * int'(y)) % 3);
    endfunction

    function automatic elem_t gadd(input elem_t x, input elem_t y);
        elem_t r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = tadd(x[2*i +: 2], y[2*i +: 2]);
        return r;
    endfunction

    function automatic elem_t gscale(input elem_t x, input logic [1:0] s);
        elem_t r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = tmul(x[2*i +: 2], s);
        return r;
    endfunction

    // x^593 = 2x^112 + 1 (mod p)
    function automatic elem_t gmulx(input elem_t x);
        elem_t      r;
        logic [1:0] top;
        top = x[W-1 -: 2];
        r = x << 2;
        r[225:224] = tadd(r[225:224], tmul(2'd2, top));
        r[1:0]     = top;
        return r;
    endfunction

    // Reference: LSB-first shift-and-add.
    function automatic elem_t gmul(input elem_t x, input elem_t y);
        elem_t acc;
        elem_t yx;
        acc = '0;
        yx  = y;
        for (int i = 0; i < M; i++) begin
            acc = gadd(acc, gscale(yx, x[2*i +: 2]));
            yx  = gmulx(yx);
        end
        return acc;
    endfunction

    function automatic elem_t rand_elem();
        elem_t r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    // ---------------- behavioural PE ----------------
    function automatic elem_t pe_step(input elem_t r3, input elem_t bb, input logic [5:0] e);
        elem_t bx, bx2, acc;
        bx  = gmulx(bb);
        bx2 = gmulx(bx);
        acc = gmulx(gmulx(gmulx(r3)));
        acc = gadd(acc, gscale(bx2, e[5:4]));
        acc = gadd(acc, gscale(bx, e[3:2]));
        return gadd(acc, gscale(bb, e[1:0]));
    endfunction

    logic [CW-1:0] pe_r0;
    elem_t         pe_r1, pe_r3;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_r0 <= '0;
            pe_r1 <= '0;
            pe_r3 <= '0;
        end else begin
            case (pe_ctrl)
                11'h7C0: begin
                    pe_r0 <= pe_d0;
                    pe_r1 <= pe_d1;
                end
                11'h03F: begin
                    pe_r0 <= pe_r0 << 6;
                    pe_r3 <= pe_step(pe_r3, pe_r1, pe_r0[CW-1 -: 6]);
                end
                11'h000: pe_r3 <= '0;
                default: ;
            endcase
        end
    end

    assign pe_out = pe_r3;

    // ---------------- checking ----------------
    task automatic check(input string name, input cval_t act, input cval_t exp);
        int d;
        n_tests++;
        if (act !== exp) begin
            d = 0;
            for (int i = 0; i < CW / 2; i++) begin
                if (act[2*i +: 2] !== exp[2*i +: 2]) begin
                    d = i;
                    break;
                end
            end
            n_fail++;
            $display("FAIL %s: trit %0d got %0d want %0d, low64 got %h want %h",
                     name, d, act[2*d +: 2], exp[2*d +: 2], act[63:0], exp[63:0]);
        end
    endtask

    // Scoreboard: pop one expected product per consumed result.
    always @(negedge clk) begin
        sb_t e;
        if (reset && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", CW'(1'b1), CW'(1'b0));
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_res"}, CW'(res), CW'(e.exp));
            end
        end
    end

    task automatic run_op(input elem_t av, input elem_t bv, input elem_t ex, input string name);
        int         waited;
        int         bad;
        logic [10:0] ec;
        waited = 0;
        bad    = 0;
        while (!in_ready && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_in_ready"}, CW'(in_ready), CW'(1'b1));
        if (!in_ready) return;
        in_valid = 1'b1;
        a = av;
        b = bv;
        sb_q.push_back('{ex, name});
        @(posedge clk); #1;
        // Garbage offered while busy must be ignored.
        a = rand_elem();
        b = rand_elem();
        for (int k = 1; k <= 201; k++) begin
            if (k == 1) begin
                check({name, "_pe_d0"}, CW'(pe_d0), CW'(av));
                check({name, "_pe_d1"}, CW'(pe_d1), CW'(bv));
                check({name, "_pe_d2"}, CW'(pe_d2), CW'(bv));
            end
            ec = (k == 1) ? 11'h7C0 : (k <= 199) ? 11'h03F : 11'h000;
            if (pe_ctrl !== ec || busy !== (k <= 200) || res_valid !== (k == 201)) bad++;
            if (k == 200) in_valid = 1'b0;
            if (k < 201) begin
                @(posedge clk); #1;
            end
        end
        check({name, "_ctrl_seq_bad_cycles"}, CW'(bad), CW'(0));
        check({name, "_latency"}, CW'(res_valid), CW'(1'b1));
        if (res_ready) begin
            @(posedge clk); #1;
            check({name, "_valid_pulse"}, CW'(res_valid), CW'(1'b0));
        end
    endtask

    vec_t vecs[6];

    initial begin
        elem_t one, two, xpoly, x592, red_exp, rb;
        int    bad;

        reset     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  CW'(in_ready),  CW'(1'b1));
        check("rst_busy",      CW'(busy),      CW'(1'b0));
        check("rst_res_valid", CW'(res_valid), CW'(1'b0));
        check("rst_pe_ctrl",   CW'(pe_ctrl),   CW'(11'h000));
        check("rst_res",       CW'(res),       CW'(0));
        check("rst_pe_d0",     CW'(pe_d0),     CW'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        one = '0;   one[1:0] = 2'b01;
        two = '0;   two[1:0] = 2'b10;
        xpoly = '0; xpoly[3:2] = 2'b01;
        x592 = '0;  x592[1185:1184] = 2'b01;
        red_exp = '0; red_exp[225:224] = 2'b10; red_exp[1:0] = 2'b01;
        rb = rand_elem();

        vecs[0] = '{one,  rb,    rb,      "identity"};
        vecs[1] = '{two,  two,   one,     "scalar"};
        vecs[2] = '{x592, xpoly, red_exp, "reduction"};
        for (int i = 3; i < 6; i++) begin
            vecs[i].a    = rand_elem();
            vecs[i].b    = rand_elem();
            vecs[i].exp  = gmul(vecs[i].a, vecs[i].b);
            vecs[i].name = $sformatf("rand%0d", i - 3);
        end

        for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Backpressure: result held for 500 cycles, accept blocked despite in_valid.
        res_ready = 1'b0;
        run_op(vecs[1].b, vecs[0].b, gmul(vecs[1].b, vecs[0].b), "bp_first");
        in_valid = 1'b1;
        a = rand_elem();
        b = rand_elem();
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (res !== gmul(vecs[1].b, vecs[0].b) && i == 0) bad++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("bp_hold_res", CW'(res), CW'(gmul(vecs[1].b, vecs[0].b)));
        check("bp_hold_bad_cycles", CW'(bad), CW'(0));
        in_valid  = 1'b0;
        res_ready = 1'b1;
        #1;
        check("bp_no_bypass", CW'(in_ready), CW'(1'b0));
        @(posedge clk); #1;
        check("bp_ready_after", CW'(in_ready), CW'(1'b1));
        check("bp_valid_after", CW'(res_valid), CW'(1'b0));
        run_op(vecs[3].b, vecs[4].a, gmul(vecs[3].b, vecs[4].a), "bp_second");

        // Reset 100 cycles into MULT.
        in_valid = 1'b1;
        a = rand_elem();
        b = rand_elem();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (101) begin
            @(posedge clk); #1;
        end
        check("mid_pre_ctrl", CW'(pe_ctrl), CW'(11'h03F));
        reset = 1'b0;
        #1;
        check("mid_rst_ctrl",      CW'(pe_ctrl),   CW'(11'h000));
        check("mid_rst_busy",      CW'(busy),      CW'(1'b0));
        check("mid_rst_res_valid", CW'(res_valid), CW'(1'b0));
        check("mid_rst_in_ready",  CW'(in_ready),  CW'(1'b1));
        check("mid_rst_res",       CW'(res),       CW'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_op(one, xpoly, xpoly, "post_reset");

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("sb_drain", CW'(sb_q.size()), CW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
